// File: rtl/ct_clk_pkg.sv
// ---------------------------------------------------------------------------
// ct_clk_pkg
// Shared definitions for the core clock-gate sequencer:
//   - wake/activity source bit positions and source count
//   - one-hot FSM state encoding and the bit index of each state
// ---------------------------------------------------------------------------
package ct_clk_pkg;

  localparam int CT_CLK_SRC_NUM = 7;

  // Wake/activity source bit positions within the source vector.
  localparam int SRC_NORMAL     = 0;
  localparam int SRC_INT_WAKEUP = 1;
  localparam int SRC_DBG_WAKEUP = 2;
  localparam int SRC_SNOOP      = 3;
  localparam int SRC_HAD_CLK_EN = 4;
  localparam int SRC_PMP_SEL    = 5;
  localparam int SRC_ICG_EN     = 6;

  // One-hot state bit positions; outputs decode single bits of the state
  // register so they stay glitch-free.
  localparam int ST_RUN_IDX   = 0;
  localparam int ST_DRAIN_IDX = 1;
  localparam int ST_GATED_IDX = 2;
  localparam int ST_WAKE_IDX  = 3;

  typedef enum logic [3:0] {
    ST_RUN   = 4'b0001,
    ST_DRAIN = 4'b0010,
    ST_GATED = 4'b0100,
    ST_WAKE  = 4'b1000
  } ct_clk_state_e;

endpackage

// File: rtl/ct_clk_icg_ctrl.sv
// ---------------------------------------------------------------------------
// ct_clk_icg_ctrl
// Sequencer for the core's global clock gate. ORs the wake/activity sources,
// applies a programmable idle hysteresis before gating and a fixed wake-up
// delay before releasing the CP0 gate-ack.
//
// Ports:
//   forever_coreclk     in  ungated core clock (only clock)
//   cpurst_b            in  asynchronous active-low reset
//   biu_xx_normal_work  in  source 0        biu_xx_int_wakeup  in  source 1
//   biu_xx_dbg_wakeup   in  source 2        biu_xx_snoop_vld   in  source 3
//   had_xx_clk_en       in  source 4        biu_xx_pmp_sel     in  source 5
//   cp0_xx_core_icg_en  in  source 6
//   cp0_clk_gate_req    in  level request from CP0 to gate the core clock
//   cp0_clk_idle_cnt    in  idle hysteresis in cycles, sampled on DRAIN entry
//   clk_xx_core_clk_en  out enable to the core ICG (state-bit decode)
//   clk_cp0_gate_ack    out high while gated or waking (state-bit decode)
//   clk_cp0_wake_cause  out sources that ended the last gated period
// ---------------------------------------------------------------------------
module ct_clk_icg_ctrl
  import ct_clk_pkg::*;
#(
  parameter int IDLE_W   = 8,
  parameter int WAKE_DLY = 4
) (
  input  logic                      forever_coreclk,
  input  logic                      cpurst_b,
  input  logic                      biu_xx_normal_work,
  input  logic                      biu_xx_int_wakeup,
  input  logic                      biu_xx_dbg_wakeup,
  input  logic                      biu_xx_snoop_vld,
  input  logic                      had_xx_clk_en,
  input  logic                      biu_xx_pmp_sel,
  input  logic                      cp0_xx_core_icg_en,
  input  logic                      cp0_clk_gate_req,
  input  logic [IDLE_W-1:0]         cp0_clk_idle_cnt,
  output logic                      clk_xx_core_clk_en,
  output logic                      clk_cp0_gate_ack,
  output logic [CT_CLK_SRC_NUM-1:0] clk_cp0_wake_cause
);

  // WAKE counts down from WAKE_DLY-1 so RUN is reached WAKE_DLY edges after
  // the wake-up edge.
  localparam logic [IDLE_W-1:0] WAKE_CNT_INIT = IDLE_W'(WAKE_DLY - 1);

  logic [CT_CLK_SRC_NUM-1:0] w_src;
  logic                      w_wake;
  ct_clk_state_e             r_state;
  ct_clk_state_e             w_state_nxt;
  logic [IDLE_W-1:0]         r_cnt;
  logic [IDLE_W-1:0]         w_cnt_nxt;
  logic [CT_CLK_SRC_NUM-1:0] r_cause;
  logic [CT_CLK_SRC_NUM-1:0] w_cause_nxt;

  always_comb begin
    w_src                 = '0;
    w_src[SRC_NORMAL]     = biu_xx_normal_work;
    w_src[SRC_INT_WAKEUP] = biu_xx_int_wakeup;
    w_src[SRC_DBG_WAKEUP] = biu_xx_dbg_wakeup;
    w_src[SRC_SNOOP]      = biu_xx_snoop_vld;
    w_src[SRC_HAD_CLK_EN] = had_xx_clk_en;
    w_src[SRC_PMP_SEL]    = biu_xx_pmp_sel;
    w_src[SRC_ICG_EN]     = cp0_xx_core_icg_en;
  end

  assign w_wake = |w_src;

  // Next-state logic. The shared counter only moves in DRAIN and WAKE and
  // never decrements past zero.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    unique case (r_state)
      ST_RUN: begin
        // An active source in the same cycle as the request keeps us running.
        if (cp0_clk_gate_req && !w_wake) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = cp0_clk_idle_cnt;
        end
      end
      ST_DRAIN: begin
        if (w_wake || !cp0_clk_gate_req) begin
          w_state_nxt = ST_RUN;
        end else if (r_cnt == '0) begin
          w_state_nxt = ST_GATED;
        end else begin
          w_cnt_nxt = r_cnt - IDLE_W'(1);
        end
      end
      ST_GATED: begin
        // A withdrawn request with no source captures an all-zero cause.
        if (w_wake || !cp0_clk_gate_req) begin
          w_state_nxt = ST_WAKE;
          w_cnt_nxt   = WAKE_CNT_INIT;
          w_cause_nxt = w_src;
        end
      end
      ST_WAKE: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - IDLE_W'(1);
        end
      end
      default: begin
        // Illegal encoding: fall back to the safe clock-running state.
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge forever_coreclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_cause <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values.
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Outputs are single-bit decodes of the one-hot state register, so the ICG
  // enable cannot glitch and no input reaches an output combinationally.
  assign clk_xx_core_clk_en = ~r_state[ST_GATED_IDX];
  assign clk_cp0_gate_ack   = r_state[ST_GATED_IDX] | r_state[ST_WAKE_IDX];
  assign clk_cp0_wake_cause = r_cause;

endmodule

// File: tb/tb_ct_clk_icg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_clk_icg_ctrl
// Self-checking bench for ct_clk_icg_ctrl. A timestamp-based reference model
// (deadline cycles for gating and wake completion) predicts en/ack/cause after
// every clock edge and every reset assertion; directed scenarios add literal
// expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_ct_clk_icg_ctrl;

  localparam int IDLE_W   = 8;
  localparam int WAKE_DLY = 4;
  localparam int RAND_CYC = 4000;

  logic              clk;
  logic              cpurst_b;
  logic [6:0]        src_v;
  logic              req;
  logic [IDLE_W-1:0] idle;
  logic              en;
  logic              ack;
  logic [6:0]        cause;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed as deadlines rather than FSM states.
  int         m_cycle     = 0;
  bit         m_gated     = 1'b0;
  int         m_drain_end = -1;   // edge at which gating happens, -1 if not draining
  int         m_wake_end  = -1;   // edge at which ack drops, -1 if not waking
  logic [6:0] m_cause     = '0;

  ct_clk_icg_ctrl #(
    .IDLE_W   (IDLE_W),
    .WAKE_DLY (WAKE_DLY)
  ) dut (
    .forever_coreclk    (clk),
    .cpurst_b           (cpurst_b),
    .biu_xx_normal_work (src_v[0]),
    .biu_xx_int_wakeup  (src_v[1]),
    .biu_xx_dbg_wakeup  (src_v[2]),
    .biu_xx_snoop_vld   (src_v[3]),
    .had_xx_clk_en      (src_v[4]),
    .biu_xx_pmp_sel     (src_v[5]),
    .cp0_xx_core_icg_en (src_v[6]),
    .cp0_clk_gate_req   (req),
    .cp0_clk_idle_cnt   (idle),
    .clk_xx_core_clk_en (en),
    .clk_cp0_gate_ack   (ack),
    .clk_cp0_wake_cause (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model + compare process: update the model on each event the DUT reacts
  // to, then compare 1 time unit later, away from the edge.
  initial begin
    forever begin
      @(posedge clk or negedge cpurst_b);
      if (!cpurst_b) begin
        m_gated     = 1'b0;
        m_drain_end = -1;
        m_wake_end  = -1;
        m_cause     = '0;
      end else begin
        m_cycle++;
        if (m_wake_end >= 0) begin
          if (m_cycle == m_wake_end) m_wake_end = -1;
        end else if (m_gated) begin
          if ((|src_v) || !req) begin
            m_gated    = 1'b0;
            m_wake_end = m_cycle + WAKE_DLY;
            m_cause    = src_v;
          end
        end else if (m_drain_end >= 0) begin
          if ((|src_v) || !req) begin
            m_drain_end = -1;
          end else if (m_cycle == m_drain_end) begin
            m_gated     = 1'b1;
            m_drain_end = -1;
          end
        end else if (req && !(|src_v)) begin
          m_drain_end = m_cycle + int'(idle) + 1;
        end
      end
      #1;
      check("model_en",    {6'b0, en},  {6'b0, !m_gated});
      check("model_ack",   {6'b0, ack}, {6'b0, (m_gated || m_wake_end >= 0)});
      check("model_cause", cause,       m_cause);
    end
  end

  initial begin
    cpurst_b = 1'b0;
    src_v    = '0;
    req      = 1'b0;
    idle     = '0;

    // Reset held low for 5 cycles, then idle with all inputs low.
    repeat (5) @(negedge clk);
    cpurst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en",    {6'b0, en},  7'd1);
    check("rst_ack",   {6'b0, ack}, 7'd0);
    check("rst_cause", cause,       7'd0);

    // Hysteresis N=3: request sampled at edge t, gated from t+4.
    @(negedge clk); idle = 8'd3; req = 1'b1;
    @(posedge clk); #1;
    check("hyst_en_t0", {6'b0, en}, 7'd1);
    repeat (3) @(posedge clk); #1;
    check("hyst_en_t3", {6'b0, en}, 7'd1);
    @(posedge clk); #1;
    check("hyst_en_t4",  {6'b0, en},  7'd0);
    check("hyst_ack_t4", {6'b0, ack}, 7'd1);
    repeat (2) @(posedge clk); #1;
    check("gated_hold_en", {6'b0, en}, 7'd0);

    // Wake on int_wakeup + had_clk_en at edge w; snoop pulse during WAKE.
    @(negedge clk); src_v = 7'b0010010;
    @(posedge clk); #1;
    check("wake_en_w",    {6'b0, en},  7'd1);
    check("wake_ack_w",   {6'b0, ack}, 7'd1);
    check("wake_cause_w", cause,       7'b0010010);
    @(negedge clk); src_v = '0;
    @(negedge clk); src_v = 7'b0001000;
    @(negedge clk); src_v = '0;
    @(posedge clk); #1;
    check("wake_ack_w3", {6'b0, ack}, 7'd1);
    @(posedge clk); #1;
    check("wake_ack_w4",   {6'b0, ack}, 7'd0);
    check("wake_cause_w4", cause,       7'b0010010);

    // Request still high: fresh hysteresis, DRAIN from w+5, gated at w+9.
    repeat (4) @(posedge clk); #1;
    check("rehyst_en_w8", {6'b0, en}, 7'd1);
    @(posedge clk); #1;
    check("rehyst_en_w9", {6'b0, en}, 7'd0);

    // Request withdrawal in GATED: WAKE with zero cause.
    @(negedge clk); req = 1'b0;
    @(posedge clk); #1;
    check("wd_ack",   {6'b0, ack}, 7'd1);
    check("wd_en",    {6'b0, en},  7'd1);
    check("wd_cause", cause,       7'd0);
    repeat (3) @(posedge clk); #1;
    check("wd_ack_3", {6'b0, ack}, 7'd1);
    @(posedge clk); #1;
    check("wd_ack_4", {6'b0, ack}, 7'd0);

    // Hysteresis N=0: gated one edge after the request is sampled.
    @(negedge clk); idle = 8'd0; req = 1'b1;
    @(posedge clk); #1;
    check("n0_en_t0", {6'b0, en}, 7'd1);
    @(posedge clk); #1;
    check("n0_en_t1", {6'b0, en}, 7'd0);
    @(negedge clk); src_v = 7'b0100000;
    @(negedge clk); src_v = '0; req = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("pmp_cause", cause,       7'b0100000);
    check("pmp_ack",   {6'b0, ack}, 7'd0);

    // Abort in DRAIN: N=5, snoop sampled while the counter holds 2.
    @(negedge clk); idle = 8'd5; req = 1'b1;
    @(posedge clk); #1;
    repeat (4) @(negedge clk);
    src_v = 7'b0001000;
    @(posedge clk); #1;
    check("abort_en",  {6'b0, en},  7'd1);
    check("abort_ack", {6'b0, ack}, 7'd0);
    @(negedge clk); src_v = '0; req = 1'b0;
    repeat (6) @(posedge clk); #1;
    check("abort_en_late",  {6'b0, en},  7'd1);
    check("abort_ack_late", {6'b0, ack}, 7'd0);

    // Asynchronous reset while gated.
    @(negedge clk); idle = 8'd1; req = 1'b1;
    @(posedge clk);
    repeat (2) @(posedge clk); #1;
    check("areset_pre_en", {6'b0, en}, 7'd0);
    @(negedge clk); #2;
    cpurst_b = 1'b0;
    #1;
    check("areset_en",    {6'b0, en},  7'd1);
    check("areset_ack",   {6'b0, ack}, 7'd0);
    check("areset_cause", cause,       7'd0);
    repeat (2) @(negedge clk);
    req = 1'b0; cpurst_b = 1'b1;
    @(posedge clk); #1;
    check("areset_post_en",  {6'b0, en},  7'd1);
    check("areset_post_ack", {6'b0, ack}, 7'd0);

    // Randomized phase, checked by the model process every cycle.
    for (int i = 0; i < RAND_CYC; i++) begin
      @(negedge clk);
      for (int b = 0; b < 7; b++) src_v[b] = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) req = ~req;
      idle = IDLE_W'($urandom_range(0, 6));
      if ($urandom_range(0, 999) == 0) begin
        #2 cpurst_b = 1'b0;
        #1 cpurst_b = 1'b1;
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ct_clk_icg_ctrl.md
# ct_clk_icg_ctrl

Sequencer for the core's global clock gate. It ORs the wake/activity sources into a single activity term and runs a four-state machine with programmable idle hysteresis and a fixed wake-up delay. It drives a registered, glitch-free enable to the core ICG and handshakes gate entry and exit with CP0. It sits in the clock top, runs on the ungated core clock, and feeds the ICG that produces `coreclk`.

## Interface
Parameters:
- `IDLE_W`, default 8: width of the idle hysteresis counter and of `cp0_clk_idle_cnt`.
- `WAKE_DLY`, default 4: cycles the enable is high before gate-ack drops. Legal range is 1 to 2^IDLE_W−1.

Ports:
- `forever_coreclk` in 1: ungated core clock; the only clock.
- `cpurst_b` in 1: reset; asynchronous, active-low.
- `biu_xx_normal_work`, `biu_xx_int_wakeup`, `biu_xx_dbg_wakeup`, `biu_xx_snoop_vld`, `had_xx_clk_en`, `biu_xx_pmp_sel`, `cp0_xx_core_icg_en` in 1 each: wake/activity sources, bit indices 0..6 in that order.
- `cp0_clk_gate_req` in 1: level; CP0 requests gating (WFI/low-power).
- `cp0_clk_idle_cnt` in IDLE_W: idle hysteresis in cycles.
- `clk_xx_core_clk_en` out 1: registered enable to the core ICG.
- `clk_cp0_gate_ack` out 1: level; high while gated or waking.
- `clk_cp0_wake_cause` out 7: snapshot of the sources that ended the last GATED period.

## Operation
- `wake_src` = OR of the 7 source inputs.
- States (one-hot): RUN, DRAIN, GATED, WAKE. A shared down-counter `cnt` of width IDLE_W serves both DRAIN and WAKE.
- RUN: en=1, ack=0. If `gate_req & !wake_src`, go to DRAIN and load `cnt`=`cp0_clk_idle_cnt`. Otherwise stay in RUN.
- DRAIN: en=1, ack=0. Exit conditions in priority order:
  - `wake_src | !gate_req` → RUN.
  - `cnt==0` → GATED.
  - Otherwise `cnt--`.
- GATED: en=0, ack=1. If `wake_src | !gate_req`, go to WAKE, load `cnt`=WAKE_DLY−1, and capture `wake_cause`={sources}. A deasserted request with no source captures all-zero.
- WAKE: en=1, ack=1. Sources and `gate_req` are ignored. At `cnt==0` go to RUN; otherwise `cnt--`.
- `cp0_clk_idle_cnt` is sampled only on the RUN→DRAIN transition. Changes during DRAIN have no effect.
- `wake_cause` holds until the next GATED→WAKE capture and is never cleared except by reset.
- The counter never wraps. It decrements only when nonzero, in DRAIN or WAKE.

## Timing
- All outputs are flops or pure one-hot state-bit decodes, with no combinational input-to-output path. This is required for glitch-free ICG enable.
- Reset values: state=RUN, en=1, ack=0, wake_cause=0, cnt=0. The clock runs during and immediately after reset.
- Gate entry: request sampled at edge t (RUN, no source) → DRAIN from t. GATED (en=0, ack=1) from edge t+N+1, where N=`cp0_clk_idle_cnt`. N=0 gives GATED at t+1.
- Wake: source sampled at edge w in GATED → en=1 from w. ack=0 (RUN) from edge w+WAKE_DLY.
- Source and request arriving in the same cycle in RUN: stay in RUN; the source wins.
- Source arriving on the cycle `cnt==0` in DRAIN: → RUN; GATED is never entered.
- Reset asserted mid-DRAIN, GATED or WAKE: immediate asynchronous return to RUN with en=1 and ack=0.
- `gate_req` held high through WAKE→RUN with no source: re-enters DRAIN on the next edge, giving a fresh hysteresis period.

## Structure
- Shared package `ct_clk_pkg` holds:
  - the one-hot state localparams,
  - the wake-source index constants (NORMAL=0 … ICG_EN=6),
  - `CT_CLK_SRC_NUM`=7.
- Single module with no sub-module. The counter and FSM are too small to split.
- The ICG cell itself stays outside this block.

## Test plan
- Reset then idle: `cpurst_b` low for 5 cycles, then high, all inputs 0 → en=1, ack=0, cause=0 throughout.
- Hysteresis: `idle_cnt`=3, `gate_req` raised at edge 10, no sources → en drops at edge 14 and ack rises at edge 14. Also run `idle_cnt`=0: en drops 1 edge after the request is sampled.
- Abort in DRAIN: `idle_cnt`=5, `biu_xx_snoop_vld` pulsed 1 cycle at DRAIN cnt=2 → back to RUN, en never drops, ack stays 0.
- Wake timing and cause: from GATED, assert `biu_xx_int_wakeup`+`had_xx_clk_en` at edge w, WAKE_DLY=4 → en=1 at w, ack=0 at w+4, cause=7'b0010010. A later source pulse during WAKE does not change the cause.
- Request withdrawal: `gate_req` dropped in GATED with no source → WAKE, cause=0, RUN after WAKE_DLY cycles.
- Async reset mid-GATED: `cpurst_b` low while en=0 → en=1 and ack=0 without waiting for a clock edge; state is RUN after release.
